// File: rtl/sram_arb_pkg.sv
// ----------------------------------------------------------------------------
// sram_arb_pkg
// Shared types and constants for the SRAM access sequencer / arbiter.
//   state_t  : sequencer FSM states
//   owner_t  : which requester holds (or last held) the SRAM port
//   sram_req_t : one latched access (direction, address, write data)
// ----------------------------------------------------------------------------
package sram_arb_pkg;

  localparam int SRAM_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  typedef struct packed {
    logic              we;
    logic [SRAM_W-1:0] addr;
    logic [SRAM_W-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// ----------------------------------------------------------------------------
// rr_arbiter_2
// Two-way round-robin arbiter between the CPU and the debug port.
// Grant is combinational; the last-grant register advances only when the
// caller accepts the grant (i_take while a request is present).
//   i_clk     : clock, rising edge
//   i_rst_n   : synchronous active-low reset (last grant -> debug)
//   i_req_cpu : CPU request
//   i_req_dbg : debug request
//   i_take    : grant is being consumed this cycle
//   o_grant   : requester that wins this cycle
//   o_any     : at least one request present
//   o_last    : requester granted most recently
// ----------------------------------------------------------------------------
module rr_arbiter_2
  import sram_arb_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_req_cpu,
  input  logic   i_req_dbg,
  input  logic   i_take,
  output owner_t o_grant,
  output logic   o_any,
  output owner_t o_last
);

  owner_t r_last;

  assign o_any  = i_req_cpu | i_req_dbg;
  assign o_last = r_last;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    o_grant = OWN_CPU;
    if (i_req_cpu && i_req_dbg)
      o_grant = (r_last == OWN_CPU) ? OWN_DBG : OWN_CPU;
    else if (i_req_dbg)
      o_grant = OWN_DBG;
  end

  // Resetting to debug makes the CPU win the first tie after reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      r_last <= OWN_DBG;
    else if (i_take && o_any)
      r_last <= o_grant;
  end

endmodule

// File: rtl/sram_arbiter.sv
// ----------------------------------------------------------------------------
// sram_arbiter
// Multi-cycle access sequencer for a 16-bit asynchronous SRAM, shared between
// the CPU memory path and a debug/loader port.  Each access runs
// IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> DONE -> IDLE.
//   Clk                    : clock, rising edge
//   Reset                  : synchronous active-low reset
//   cpu_req/we/addr/wdata  : CPU request, held until cpu_ack
//   cpu_rdata, cpu_ack     : CPU read data (registered), completion pulse
//   dbg_req/we/addr/wdata  : debug request, held until dbg_ack
//   dbg_rdata, dbg_ack     : debug read data (registered), completion pulse
//   ADDR, Data             : SRAM address, bidirectional data bus
//   Mem_CE/UB/LB/OE/WE     : SRAM strobes, active-low
//   busy                   : sequencer not in IDLE
//   owner                  : 0 = CPU, 1 = debug (current or last grant)
// ----------------------------------------------------------------------------
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 2  // OE/WE low cycles per access, 1..15
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [SRAM_W-1:0] cpu_addr,
  input  logic [SRAM_W-1:0] cpu_wdata,
  output logic [SRAM_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [SRAM_W-1:0] dbg_addr,
  input  logic [SRAM_W-1:0] dbg_wdata,
  output logic [SRAM_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic [SRAM_W-1:0] ADDR,
  inout  wire  [SRAM_W-1:0] Data,
  output logic              Mem_CE,
  output logic              Mem_UB,
  output logic              Mem_LB,
  output logic              Mem_OE,
  output logic              Mem_WE,
  output logic              busy,
  output logic              owner
);

  state_t            r_state;
  logic [3:0]        r_cnt;
  sram_req_t         r_req;
  logic              r_data_oe;
  logic              r_ce;
  logic              r_oe;
  logic              r_we;
  logic              r_cpu_ack;
  logic              r_dbg_ack;
  logic [SRAM_W-1:0] r_cpu_rdata;
  logic [SRAM_W-1:0] r_dbg_rdata;

  owner_t            w_grant;
  owner_t            w_last;
  logic              w_any;
  logic              w_take;
  sram_req_t         w_sel_req;

  // Requests are only looked at in IDLE; elsewhere the latched copy rules.
  assign w_take = (r_state == IDLE);

  rr_arbiter_2 u_arb (
    .i_clk     (Clk),
    .i_rst_n   (Reset),
    .i_req_cpu (cpu_req),
    .i_req_dbg (dbg_req),
    .i_take    (w_take),
    .o_grant   (w_grant),
    .o_any     (w_any),
    .o_last    (w_last)
  );

  always_comb begin
    w_sel_req = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
    if (w_grant == OWN_DBG)
      w_sel_req = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};
  end

  // NOTE: the bus is released with 'z rather than muxed; the SRAM drives it
  // during reads, so our driver must be fully off whenever r_data_oe is low.
  assign Data = r_data_oe ? r_req.wdata : {SRAM_W{1'bz}};

  assign ADDR      = r_req.addr;
  assign Mem_CE    = r_ce;
  assign Mem_UB    = r_ce;   // only full-word accesses, byte lanes follow CE
  assign Mem_LB    = r_ce;
  assign Mem_OE    = r_oe;
  assign Mem_WE    = r_we;
  assign cpu_ack   = r_cpu_ack;
  assign dbg_ack   = r_dbg_ack;
  assign cpu_rdata = r_cpu_rdata;
  assign dbg_rdata = r_dbg_rdata;
  assign busy      = (r_state != IDLE);
  assign owner     = w_last;  // last-grant register doubles as the owner

  // Strobes are registered: each state's strobe values are loaded on the edge
  // that enters the state, so pins never glitch on state decode.
  // NOTE: every assignment here is non-blocking so all registers sample the
  // pre-edge values of each other, including Data captured as OE rises.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req       <= '0;
      r_data_oe   <= 1'b0;
      r_ce        <= 1'b1;
      r_oe        <= 1'b1;
      r_we        <= 1'b1;
      r_cpu_ack   <= 1'b0;
      r_dbg_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_dbg_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_req     <= w_sel_req;
            r_data_oe <= w_sel_req.we;
            r_ce      <= 1'b0;
            r_state   <= SETUP;
          end
        end
        SETUP: begin
          r_cnt <= 4'(WAIT_CYCLES - 1);
          if (r_req.we)
            r_we <= 1'b0;
          else
            r_oe <= 1'b0;
          r_state <= ACCESS;
        end
        ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_oe <= 1'b1;
            r_we <= 1'b1;
            if (w_last == OWN_DBG) begin
              r_dbg_ack <= 1'b1;
              if (!r_req.we)
                r_dbg_rdata <= Data;
            end else begin
              r_cpu_ack <= 1'b1;
              if (!r_req.we)
                r_cpu_rdata <= Data;
            end
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          // Turnaround: CE released and write data dropped after the hold cycle.
          r_ce      <= 1'b1;
          r_data_oe <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
